sram_core_responder: RTL and testbench

SRAM_CORE_RESPONDER -- requirements
Module: sram_core_responder

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_dq_iobuf.sv | 40 ++++
 rtl/sram_core_responder.sv | 161 ++++++++++++++++
 tb/tb_sram_core_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and sizes for the SRAM core responder.
// S_VERIFY exists only when SRAM_WR_VERIFY_EN is defined.
package sram_pkg;
    localparam int SRAM_AW      = 20;
    localparam int SRAM_DW      = 16;
    localparam int RD_WAIT_DEF  = 1;
    localparam int WR_PULSE_DEF = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
`ifdef SRAM_WR_VERIFY_EN
        ,
        S_VERIFY
`endif
    } state_e;
endpackage

// File: rtl/sram_dq_iobuf.sv
// SRAM data pin buffer: registered drive enable, tri-state driver and read capture.
// Exposes the raw pin value when SRAM_WR_VERIFY_EN is defined.
module sram_dq_iobuf
    import sram_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_oe,
    input  logic               i_capture,
    input  logic [SRAM_DW-1:0] i_wdata,
    output logic [SRAM_DW-1:0] o_rdata,
`ifdef SRAM_WR_VERIFY_EN
    output logic [SRAM_DW-1:0] o_dq_in,
`endif
    inout  wire  [SRAM_DW-1:0] io_dq
);
    logic               oe_q, oe_d;
    logic [SRAM_DW-1:0] rdata_q, rdata_d;

    always_comb begin
        oe_d    = i_oe;
        rdata_d = i_capture ? io_dq : rdata_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            oe_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            oe_q    <= oe_d;
            rdata_q <= rdata_d;
        end
    end

    assign io_dq   = oe_q ? i_wdata : {SRAM_DW{1'bz}};
    assign o_rdata = rdata_q;
`ifdef SRAM_WR_VERIFY_EN
    assign o_dq_in = io_dq;
`endif
endmodule

// File: rtl/sram_core_responder.sv
// Sequences single core reads/writes onto an asynchronous 16-bit SRAM.
// Define SRAM_WR_VERIFY_EN to read back every write and flag mismatches.
module sram_core_responder
    import sram_pkg::*;
#(
    parameter int RD_WAIT  = RD_WAIT_DEF,
    parameter int WR_PULSE = WR_PULSE_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               core_mem_request,
    input  logic               core_mem_wr,
    input  logic [SRAM_AW-1:0] core_mem_addr,
    input  logic [SRAM_DW-1:0] core_mem_w_value,
    output logic [SRAM_DW-1:0] core_mem_r_value,
    output logic               core_wait,
    output logic               mem_valid,
    output logic [SRAM_AW-1:0] o_SRAM_ADDR,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N,
    inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
    output logic               o_wr_err
);
    localparam logic [1:0] RD_LAST = 2'(RD_WAIT - 1);
    localparam logic [1:0] WR_LAST = 2'(WR_PULSE - 1);

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [SRAM_DW-1:0] wdata_q, wdata_d;
    logic               core_wait_q, core_wait_d;
    logic               mem_valid_q, mem_valid_d;
    logic               capture;
    logic               dq_oe;
    logic               rd_phase;
    logic               ce_n;
`ifdef SRAM_WR_VERIFY_EN
    logic [SRAM_DW-1:0] dq_in;
    logic               wr_err_q, wr_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_valid_d = 1'b0;
        capture     = 1'b0;
`ifdef SRAM_WR_VERIFY_EN
        wr_err_d    = wr_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (core_mem_request) begin
                    addr_d  = core_mem_addr;
                    wdata_d = core_mem_w_value;
                    cnt_d   = '0;
                    state_d = core_mem_wr ? S_WR_SETUP : S_RD;
                end
            end
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    capture     = 1'b1;
                    mem_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
`ifdef SRAM_WR_VERIFY_EN
            S_WR_HOLD: begin
                cnt_d   = '0;
                state_d = S_VERIFY;
            end
            S_VERIFY: begin
                if (cnt_q == RD_LAST) begin
                    if (dq_in != wdata_q) wr_err_d = 1'b1;
                    mem_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
`else
            S_WR_HOLD: begin
                mem_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        core_wait_d = (state_d != S_IDLE);
        dq_oe = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE)
             || (state_d == S_WR_HOLD);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            core_wait_q <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            core_wait_q <= core_wait_d;
            mem_valid_q <= mem_valid_d;
        end
    end

`ifdef SRAM_WR_VERIFY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) wr_err_q <= 1'b0;
        else          wr_err_q <= wr_err_d;
    end
    assign o_wr_err = wr_err_q;
    assign rd_phase = (state_q == S_RD) || (state_q == S_VERIFY);
`else
    assign o_wr_err = 1'b0;
    assign rd_phase = (state_q == S_RD);
`endif

    sram_dq_iobuf u_iobuf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_oe      (dq_oe),
        .i_capture (capture),
        .i_wdata   (wdata_q),
        .o_rdata   (core_mem_r_value),
`ifdef SRAM_WR_VERIFY_EN
        .o_dq_in   (dq_in),
`endif
        .io_dq     (io_SRAM_DQ)
    );

    // Byte lanes are always both enabled; they simply track chip enable.
    assign ce_n        = (state_q == S_IDLE);
    assign o_SRAM_CE_N = ce_n;
    assign o_SRAM_LB_N = ce_n;
    assign o_SRAM_UB_N = ce_n;
    assign o_SRAM_OE_N = !rd_phase;
    assign o_SRAM_WE_N = (state_q != S_WR_PULSE);
    assign o_SRAM_ADDR = addr_q;
    assign core_wait   = core_wait_q;
    assign mem_valid   = mem_valid_q;
endmodule

// File: tb/tb_sram_core_responder.sv
// Bench for sram_core_responder: default instance plus an RD_WAIT=3/WR_PULSE=2 instance.
// Behavioural SRAM models sit on each DQ bus; reads are scoreboarded on mem_valid.
module tb_sram_core_responder;
`ifdef SRAM_WR_VERIFY_EN
    localparam int VFY = 1;
`else
    localparam int VFY = 0;
`endif

    typedef struct packed {
        logic        wr;
        logic [15:0] data;
    } sb_t;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_r;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    sb_t exp_q[$];
    logic corrupt = 1'b0;

    logic        req0 = 0, wr0 = 0;
    logic [19:0] addr0 = 0;
    logic [15:0] wd0 = 0;
    logic [15:0] rv0;
    logic        cw0, mv0, we0, ce0, oe0, lb0, ub0, err0;
    logic [19:0] sa0;
    wire  [15:0] dq0;
    logic [15:0] mem0 [256];
    logic [15:0] rd0;

    logic        req3 = 0, wr3 = 0;
    logic [19:0] addr3 = 0;
    logic [15:0] wd3 = 0;
    logic [15:0] rv3;
    logic        cw3, mv3, we3, ce3, oe3, lb3, ub3, err3;
    logic [19:0] sa3;
    wire  [15:0] dq3;
    logic [15:0] mem3 [256];
    logic [15:0] rd3;

    sram_core_responder u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .core_mem_request(req0), .core_mem_wr(wr0),
        .core_mem_addr(addr0), .core_mem_w_value(wd0),
        .core_mem_r_value(rv0), .core_wait(cw0), .mem_valid(mv0),
        .o_SRAM_ADDR(sa0), .o_SRAM_WE_N(we0), .o_SRAM_CE_N(ce0),
        .o_SRAM_OE_N(oe0), .o_SRAM_LB_N(lb0), .o_SRAM_UB_N(ub0),
        .io_SRAM_DQ(dq0), .o_wr_err(err0)
    );

    sram_core_responder #(.RD_WAIT(3), .WR_PULSE(2)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .core_mem_request(req3), .core_mem_wr(wr3),
        .core_mem_addr(addr3), .core_mem_w_value(wd3),
        .core_mem_r_value(rv3), .core_wait(cw3), .mem_valid(mv3),
        .o_SRAM_ADDR(sa3), .o_SRAM_WE_N(we3), .o_SRAM_CE_N(ce3),
        .o_SRAM_OE_N(oe3), .o_SRAM_LB_N(lb3), .o_SRAM_UB_N(ub3),
        .io_SRAM_DQ(dq3), .o_wr_err(err3)
    );

    assign rd0 = mem0[sa0[7:0]] ^ {15'd0, corrupt};
    assign dq0 = (!ce0 && !oe0 && we0) ? rd0 : 16'hzzzz;
    assign rd3 = mem3[sa3[7:0]];
    assign dq3 = (!ce3 && !oe3 && we3) ? rd3 : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce0 && !we0) mem0[sa0[7:0]] <= dq0;
        if (!ce3 && !we3) mem3[sa3[7:0]] <= dq3;
    end

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && mv0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 1, 0);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                chk(e.wr ? "sb_rvalue_after_wr" : "sb_rvalue", rv0, e.data);
            end
        end
    end

    task automatic run0(input vec_t v);
        int lat, we_lo, oe_lo, cw_hi, addr_bad;
        sb_t e;
        @(negedge clk);
        req0 = 1'b1; wr0 = v.wr; addr0 = v.addr; wd0 = v.wdata;
        e.wr = v.wr; e.data = v.exp_r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req0 = 1'b0; wr0 = ~v.wr; addr0 = ~v.addr; wd0 = ~v.wdata;
        lat = 0; we_lo = 0; oe_lo = 0; cw_hi = 0; addr_bad = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (mv0) break;
            if (!we0) we_lo++;
            if (!oe0) oe_lo++;
            if (cw0) cw_hi++;
            if (sa0 != v.addr || ce0 || lb0 || ub0) addr_bad++;
        end
        chk(v.wr ? "wr_latency" : "rd_latency", lat,
            v.wr ? 4 + VFY : 2);
        chk("we_low_cycles", we_lo, v.wr ? 1 : 0);
        chk("oe_low_cycles", oe_lo, v.wr ? VFY : 1);
        chk("core_wait_cycles", cw_hi, v.wr ? 3 + VFY : 1);
        chk("addr_ce_stable", addr_bad, 0);
    endtask

    vec_t vecs[8];
    logic [7:0] cw_hist, mv_hist;
    int lat, we_lo, oe_lo, addr_bad, mv_seen;

    initial begin
        sb_t e;
        vecs[0] = '{1'b1, 20'h00005, 16'h1F0A, 16'h0000};
        vecs[1] = '{1'b0, 20'h00005, 16'h0000, 16'h1F0A};
        vecs[2] = '{1'b1, 20'h06800, 16'hA5C3, 16'h1F0A};
        vecs[3] = '{1'b0, 20'h06800, 16'h0000, 16'hA5C3};
        vecs[4] = '{1'b1, 20'hFFFFF, 16'hFFFF, 16'hA5C3};
        vecs[5] = '{1'b1, 20'h00033, 16'h1234, 16'hA5C3};
        vecs[6] = '{1'b0, 20'hFFFFF, 16'h0000, 16'hFFFF};
        vecs[7] = '{1'b0, 20'h00033, 16'h0000, 16'h1234};

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {cw0, mv0, ce0, oe0, we0, lb0, ub0, err0}, 8'b0011_1110);
        chk("rst_rvalue", rv0, 0);
        chk("rst_addr", sa0, 0);
        chk("rst_ctrl_d3", {cw3, mv3, ce3, oe3, we3}, 5'b00111);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run0(vecs[i]);
        chk("wr_err_clean", err0, 0);

        // Request held high across write then read of the same word.
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 20'h06800; wd0 = 16'h5A5A;
        e.wr = 1'b1; e.data = 16'h1234; exp_q.push_back(e);
        e.wr = 1'b0; e.data = 16'h5A5A; exp_q.push_back(e);
        @(posedge clk);
        #1;
        wr0 = 1'b0; wd0 = 16'h0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cw_hist[c] = cw0;
            mv_hist[c] = mv0;
            if (c == 4 + VFY) req0 = 1'b0;
        end
        chk("b2b_core_wait", cw_hist, VFY ? 8'b0010_1111 : 8'b0001_0111);
        chk("b2b_mem_valid", mv_hist, VFY ? 8'b0101_0000 : 8'b0010_1000);

        // Reset in the middle of the write pulse.
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 20'h00010; wd0 = 16'hBEEF;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_we_low", we0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {we0, ce0, oe0, cw0, mv0}, 5'b11100);
        chk("midrst_addr", sa0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mv_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (mv0) mv_seen++;
        end
        chk("no_valid_after_rst", mv_seen, 0);
        chk("rvalue_after_rst", rv0, 0);
        run0('{1'b0, 20'h00005, 16'h0000, 16'h1F0A});

        // Slow instance: write then read the top address.
        @(negedge clk);
        req3 = 1'b1; wr3 = 1'b1; addr3 = 20'hFFFFF; wd3 = 16'h0F0F;
        @(posedge clk);
        #1;
        req3 = 1'b0; addr3 = 20'h0; wd3 = 16'h0;
        lat = 0; we_lo = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (mv3) break;
            if (!we3) we_lo++;
        end
        chk("d3_wr_latency", lat, 5 + 3 * VFY);
        chk("d3_we_low_cycles", we_lo, 2);
        @(negedge clk);
        req3 = 1'b1; wr3 = 1'b0; addr3 = 20'hFFFFF;
        @(posedge clk);
        #1;
        req3 = 1'b0; wr3 = 1'b1; addr3 = 20'h0;
        lat = 0; oe_lo = 0; addr_bad = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (mv3) break;
            if (!oe3) oe_lo++;
            if (sa3 != 20'hFFFFF || ce3) addr_bad++;
        end
        chk("d3_rd_latency", lat, 4);
        chk("d3_oe_low_cycles", oe_lo, 3);
        chk("d3_addr_stable", addr_bad, 0);
        chk("d3_rvalue", rv3, 16'h0F0F);

`ifdef SRAM_WR_VERIFY_EN
        corrupt = 1'b1;
        run0('{1'b1, 20'h00020, 16'h0001, 16'h1F0A});
        chk("wr_err_set", err0, 1);
        run0('{1'b0, 20'h00020, 16'h0000, 16'h0000});
        chk("wr_err_sticky", err0, 1);
        corrupt = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("wr_err_rst", err0, 0);
        rst_n = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
